// File: rtl/alu_stage.sv
// alu_stage: registered 8-bit ALU and processor-status (P) unit that sits
// behind the register-file read port of the microcoded 65C02 core.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   R          operand from register-file read port
//   M          memory / data-bus operand
//   alu_op     0 PASSR 1 PASSM 2 ORA 3 AND 4 EOR 5 ADC 6 SBC 7 ASL
//              8 LSR 9 ROL A ROR B INC C DEC D CMP E BIT F NOP
//   start      accept alu_op/R/M this cycle (ignored while busy)
//   flag_op    0 none 1 CLC 2 SEC 3 CLD 4 SED 5 CLI 6 SEI 7 CLV
//   p_load     load P from M (PLP/RTI)
//   out        registered result for register-file write-back
//   out_valid  one-cycle pulse marking a write-back result on out
//   busy       decimal ADC/SBC adjust cycle in progress
//   P          {N,V,1,1,D,I,Z,C}
//
// Binary ops complete in one cycle. With DECIMAL_EN=1 and D=1, ADC/SBC take
// two cycles: the binary sum is captured first, the BCD adjust follows.
module alu_stage #(
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] R,
    input  logic [7:0] M,
    input  logic [3:0] alu_op,
    input  logic       start,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       busy,
    output logic [7:0] P
);

    localparam logic [3:0] OP_PASSR = 4'h0, OP_PASSM = 4'h1, OP_ORA = 4'h2,
                           OP_AND   = 4'h3, OP_EOR   = 4'h4, OP_ADC = 4'h5,
                           OP_SBC   = 4'h6, OP_ASL   = 4'h7, OP_LSR = 4'h8,
                           OP_ROL   = 4'h9, OP_ROR   = 4'hA, OP_INC = 4'hB,
                           OP_DEC   = 4'hC, OP_CMP   = 4'hD, OP_BIT = 4'hE;

    typedef enum logic {IDLE, ADJ} state_t;

    state_t state, state_nx;
    logic   n_r, v_r, d_r, i_r, z_r, c_r;
    logic   n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;
    logic [7:0] out_nx;
    logic       vld_nx;

    // Decimal pipeline registers, valid only while state==ADJ.
    logic [8:0] sum_p1;
    logic       hc_p1, v_p1, sub_p1;

    // BCD adjust of a captured binary sum. Returns {carry, adjusted value}.
    // SBC keeps the raw carry (no borrow inversion).
    function automatic logic [8:0] bcd_adjust(input logic [8:0] s,
                                              input logic       hc,
                                              input logic       sub);
        logic [7:0] adj;
        logic       cy;
        adj = 8'h00;
        if (sub) begin
            if (!hc)   adj = adj - 8'h06;
            if (!s[8]) adj = adj - 8'h60;
            cy = s[8];
        end else begin
            if (hc || (s[3:0] > 4'h9)) adj = adj + 8'h06;
            cy = s[8] || (s[7:0] > 8'h99);
            if (cy) adj = adj + 8'h60;
        end
        return {cy, s[7:0] + adj};
    endfunction

    // Shared adder: SBC is R + ~M + C.
    logic [7:0] b_op;
    logic [8:0] sum9;
    logic [8:0] cmp9;
    logic       hc_bin, v_bin, go_dec;
    logic [8:0] adj9;

    assign b_op   = (alu_op == OP_SBC) ? ~M : M;
    assign sum9   = {1'b0, R} + {1'b0, b_op} + {8'b0, c_r};
    // Carry into bit 4 recovered from the sum bits.
    assign hc_bin = sum9[4] ^ R[4] ^ b_op[4];
    assign v_bin  = (R[7] == b_op[7]) && (sum9[7] != R[7]);
    assign cmp9   = {1'b0, R} + {1'b0, ~M} + 9'd1;
    // Mode is taken from D as registered before this edge, so a SED/CLD in
    // the same cycle does not affect the op being started.
    assign go_dec = DECIMAL_EN && d_r && ((alu_op == OP_ADC) || (alu_op == OP_SBC));
    assign adj9   = bcd_adjust(sum_p1, hc_p1, sub_p1);

    logic [7:0] res;
    logic       wr, nz, capture;

    always_comb begin
        state_nx = state;
        out_nx   = out;
        vld_nx   = 1'b0;
        capture  = 1'b0;
        res      = 8'h00;
        wr       = 1'b0;
        nz       = 1'b0;
        n_nx = n_r; v_nx = v_r; d_nx = d_r; i_nx = i_r; z_nx = z_r; c_nx = c_r;

        // Lowest priority: explicit flag instructions.
        case (flag_op)
            3'd1: c_nx = 1'b0;
            3'd2: c_nx = 1'b1;
            3'd3: d_nx = 1'b0;
            3'd4: d_nx = 1'b1;
            3'd5: i_nx = 1'b0;
            3'd6: i_nx = 1'b1;
            3'd7: v_nx = 1'b0;
            default: ;
        endcase

        if (state == ADJ) begin
            out_nx   = adj9[7:0];
            vld_nx   = 1'b1;
            n_nx     = adj9[7];
            z_nx     = (adj9[7:0] == 8'h00);
            c_nx     = adj9[8];
            v_nx     = v_p1;
            state_nx = IDLE;
        end else if (start) begin
            if (go_dec) begin
                capture  = 1'b1;
                state_nx = ADJ;
            end else begin
                case (alu_op)
                    OP_PASSR: begin res = R;     wr = 1'b1; nz = 1'b1; end
                    OP_PASSM: begin res = M;     wr = 1'b1; nz = 1'b1; end
                    OP_ORA:   begin res = R | M; wr = 1'b1; nz = 1'b1; end
                    OP_AND:   begin res = R & M; wr = 1'b1; nz = 1'b1; end
                    OP_EOR:   begin res = R ^ M; wr = 1'b1; nz = 1'b1; end
                    OP_ADC, OP_SBC: begin
                        res = sum9[7:0]; wr = 1'b1; nz = 1'b1;
                        c_nx = sum9[8]; v_nx = v_bin;
                    end
                    OP_ASL: begin res = {R[6:0], 1'b0}; wr = 1'b1; nz = 1'b1; c_nx = R[7]; end
                    OP_LSR: begin res = {1'b0, R[7:1]}; wr = 1'b1; nz = 1'b1; c_nx = R[0]; end
                    OP_ROL: begin res = {R[6:0], c_r};  wr = 1'b1; nz = 1'b1; c_nx = R[7]; end
                    OP_ROR: begin res = {c_r, R[7:1]};  wr = 1'b1; nz = 1'b1; c_nx = R[0]; end
                    OP_INC: begin res = R + 8'h01; wr = 1'b1; nz = 1'b1; end
                    OP_DEC: begin res = R - 8'h01; wr = 1'b1; nz = 1'b1; end
                    OP_CMP: begin res = cmp9[7:0]; nz = 1'b1; c_nx = cmp9[8]; end
                    OP_BIT: begin
                        n_nx = M[7];
                        v_nx = M[6];
                        z_nx = ((R & M) == 8'h00);
                    end
                    default: ;
                endcase
                if (wr) begin
                    out_nx = res;
                    vld_nx = 1'b1;
                end
                if (nz) begin
                    n_nx = res[7];
                    z_nx = (res == 8'h00);
                end
            end
        end

        // Highest priority: PLP/RTI load.
        if (p_load) begin
            n_nx = M[7]; v_nx = M[6]; d_nx = M[3];
            i_nx = M[2]; z_nx = M[1]; c_nx = M[0];
        end
    end

    // ---- stage p0 -> p1: control, result and flag registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out       <= 8'h00;
            out_valid <= 1'b0;
            n_r <= 1'b0; v_r <= 1'b0; d_r <= 1'b0;
            i_r <= 1'b1; z_r <= 1'b0; c_r <= 1'b0;
        end else begin
            state     <= state_nx;
            out       <= out_nx;
            out_valid <= vld_nx;
            n_r <= n_nx; v_r <= v_nx; d_r <= d_nx;
            i_r <= i_nx; z_r <= z_nx; c_r <= c_nx;
        end
    end

    // ---- stage p0 -> p1: decimal operand capture ----
    always_ff @(posedge clk) begin
        if (capture) begin
            sum_p1 <= sum9;
            hc_p1  <= hc_bin;
            v_p1   <= v_bin;
            sub_p1 <= (alu_op == OP_SBC);
        end
    end

    assign busy = (state == ADJ);
    assign P    = {n_r, v_r, 2'b11, d_r, i_r, z_r, c_r};

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;

    logic       clk = 1'b0;
    logic       reset, start, p_load;
    logic [7:0] R, M;
    logic [3:0] alu_op;
    logic [2:0] flag_op;
    logic [7:0] out, P, out_b, P_b;
    logic       out_valid, busy, out_valid_b, busy_b;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_out;

    alu_stage #(.DECIMAL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .R(R), .M(M), .alu_op(alu_op), .start(start),
        .flag_op(flag_op), .p_load(p_load), .out(out), .out_valid(out_valid),
        .busy(busy), .P(P)
    );

    alu_stage #(.DECIMAL_EN(1'b0)) dut_bin (
        .clk(clk), .reset(reset), .R(R), .M(M), .alu_op(alu_op), .start(start),
        .flag_op(flag_op), .p_load(p_load), .out(out_b), .out_valid(out_valid_b),
        .busy(busy_b), .P(P_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] r;
        logic [7:0] m;
        logic       cin;
        logic [7:0] exp_out;
        logic       exp_vld;
        logic [7:0] exp_p;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input logic [7:0] v);
        p_load = 1'b1;
        M      = v;
        tick();
        p_load = 1'b0;
    endtask

    // Reference BCD arithmetic on decimal integers. Returns {carry, result}.
    function automatic logic [8:0] bcd_model(input logic sub, input logic [7:0] r,
                                             input logic [7:0] m, input logic c);
        int a, b, s;
        logic cy;
        a = int'(r[7:4]) * 10 + int'(r[3:0]);
        b = int'(m[7:4]) * 10 + int'(m[3:0]);
        if (!sub) begin
            s  = a + b + int'(c);
            cy = (s >= 100);
            if (cy) s = s - 100;
        end else begin
            s  = a - b - (1 - int'(c));
            cy = (s >= 0);
            if (!cy) s = s + 100;
        end
        return {cy, 4'(s / 10), 4'(s % 10)};
    endfunction

    // Signed overflow of the binary add/subtract.
    function automatic logic vflag(input logic sub, input logic [7:0] r,
                                   input logic [7:0] m, input logic c);
        int a, b, s;
        a = $signed(r);
        b = sub ? $signed(~m) : $signed(m);
        s = a + b + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5) begin
            tick();
            n++;
        end
        chk(name, 8'(exp_q.size()), 8'd0);
    endtask

    // Decimal ADC/SBC from a known P (D=1, I=1, V=0).
    task automatic run_dec(input logic sub, input logic [7:0] r, input logic [7:0] m,
                           input logic cin);
        logic [8:0] e;
        logic [7:0] ep;
        e = bcd_model(sub, r, m, cin);
        ep = {e[7], vflag(sub, r, m, cin), 2'b11, 1'b1, 1'b1, (e[7:0] == 8'h00), e[8]};
        set_p(8'h3C | {7'b0, cin});
        alu_op = sub ? 4'h6 : 4'h5;
        R = r;
        M = m;
        start = 1'b1;
        exp_q.push_back(e[7:0]);
        tick();
        start = 1'b0;
        chk("dec_busy1", {7'b0, busy}, 8'd1);
        chk("dec_vld1", {7'b0, out_valid}, 8'd0);
        tick();
        chk($sformatf("dec_p_%02h_%02h", r, m), P, ep);
        chk("dec_busy2", {7'b0, busy}, 8'd0);
        drain("dec_drain");
    endtask

    // Scoreboard: every out_valid pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=%02h expected=none", out);
            end else begin
                chk("out", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //            op     r      m      cin   out    vld   P
        tbl[0]  = '{4'h5, 8'h50, 8'h50, 1'b0, 8'hA0, 1'b1, 8'hF4}; // ADC overflow
        tbl[1]  = '{4'h5, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h37}; // ADC carry/zero
        tbl[2]  = '{4'h6, 8'h50, 8'hF0, 1'b1, 8'h60, 1'b1, 8'h34}; // SBC borrow
        tbl[3]  = '{4'h6, 8'h80, 8'h01, 1'b0, 8'h7E, 1'b1, 8'h75}; // SBC overflow
        tbl[4]  = '{4'h2, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b1, 8'hB4}; // ORA
        tbl[5]  = '{4'h3, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b1, 8'h36}; // AND
        tbl[6]  = '{4'h4, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h36}; // EOR
        tbl[7]  = '{4'h7, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 8'h35}; // ASL
        tbl[8]  = '{4'h9, 8'h40, 8'h00, 1'b1, 8'h81, 1'b1, 8'hB4}; // ROL
        tbl[9]  = '{4'h8, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 8'h37}; // LSR
        tbl[10] = '{4'hA, 8'h02, 8'h00, 1'b1, 8'h81, 1'b1, 8'hB4}; // ROR
        tbl[11] = '{4'hB, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h37}; // INC wrap
        tbl[12] = '{4'hC, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 8'hB4}; // DEC wrap
        tbl[13] = '{4'h0, 8'h00, 8'h55, 1'b0, 8'h00, 1'b1, 8'h36}; // PASSR
        tbl[14] = '{4'h1, 8'h11, 8'h80, 1'b0, 8'h80, 1'b1, 8'hB4}; // PASSM
        tbl[15] = '{4'hD, 8'h40, 8'h40, 1'b0, 8'h00, 1'b0, 8'h37}; // CMP equal
        tbl[16] = '{4'hD, 8'h10, 8'h20, 1'b0, 8'h00, 1'b0, 8'hB4}; // CMP less
        tbl[17] = '{4'hE, 8'h0F, 8'hC0, 1'b0, 8'h00, 1'b0, 8'hF6}; // BIT
        tbl[18] = '{4'hF, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 8'h35}; // NOP

        reset = 1'b1; start = 1'b0; p_load = 1'b0; flag_op = 3'd0;
        alu_op = 4'hF; R = 8'h00; M = 8'h00;
        repeat (3) tick();
        chk("rst_out", out, 8'h00);
        chk("rst_vld", {7'b0, out_valid}, 8'd0);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_p", P, 8'h34);
        chk("rst_p_bin", P_b, 8'h34);
        reset = 1'b0;
        last_out = 8'h00;

        // Binary table, D=0.
        for (int k = 0; k < NV; k++) begin
            set_p(8'h34 | {7'b0, tbl[k].cin});
            alu_op = tbl[k].op;
            R      = tbl[k].r;
            M      = tbl[k].m;
            start  = 1'b1;
            if (tbl[k].exp_vld) exp_q.push_back(tbl[k].exp_out);
            tick();
            start = 1'b0;
            chk($sformatf("vec%0d_p", k), P, tbl[k].exp_p);
            chk($sformatf("vec%0d_busy", k), {7'b0, busy}, 8'd0);
            if (tbl[k].exp_vld) last_out = tbl[k].exp_out;
            else chk($sformatf("vec%0d_hold", k), out, last_out);
        end
        drain("table_drain");

        // Decimal ADC after SED, C=0.
        set_p(8'h34);
        flag_op = 3'd4;
        tick();
        flag_op = 3'd0;
        chk("sed_p", P, 8'h3C);
        alu_op = 4'h5; R = 8'h19; M = 8'h28; start = 1'b1;
        exp_q.push_back(8'h47);
        tick();
        start = 1'b0;
        chk("adc19_busy", {7'b0, busy}, 8'd1);
        chk("adc19_vld", {7'b0, out_valid}, 8'd0);
        tick();
        chk("adc19_p", P, 8'h3C);
        drain("adc19_drain");
        alu_op = 4'h5; R = 8'h99; M = 8'h01; start = 1'b1;
        exp_q.push_back(8'h00);
        tick();
        start = 1'b0;
        chk("adc99_busy", {7'b0, busy}, 8'd1);
        tick();
        chk("adc99_p", P, 8'h3F);
        drain("adc99_drain");

        // Decimal SBC 00-01 with C=1; binary-only instance finishes in one cycle.
        flag_op = 3'd2;
        tick();
        flag_op = 3'd0;
        alu_op = 4'h6; R = 8'h00; M = 8'h01; start = 1'b1;
        exp_q.push_back(8'h99);
        tick();
        start = 1'b0;
        chk("sbc_bin_out", out_b, 8'hFF);
        chk("sbc_bin_vld", {7'b0, out_valid_b}, 8'd1);
        chk("sbc_bin_busy", {7'b0, busy_b}, 8'd0);
        chk("sbc_bin_p", P_b, 8'hBC);
        chk("sbc_dec_busy", {7'b0, busy}, 8'd1);
        tick();
        chk("sbc_dec_p", P, 8'hBC);
        drain("sbc_drain");

        // Start during ADJ is ignored.
        set_p(8'h3C);
        alu_op = 4'h5; R = 8'h12; M = 8'h34; start = 1'b1;
        exp_q.push_back(8'h46);
        tick();
        alu_op = 4'h0; R = 8'hAA; start = 1'b1;
        tick();
        start = 1'b0;
        alu_op = 4'hF;
        tick();
        tick();
        chk("busy_start_out", out, 8'h46);
        chk("busy_start_p", P, 8'h3C);
        drain("busy_start_drain");

        // Random valid-BCD decimal ops against the decimal model.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] rr, mm;
            rr = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            mm = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_dec(1'($urandom_range(0, 1)), rr, mm, 1'($urandom_range(0, 1)));
        end

        // Reset while in ADJ aborts the op.
        set_p(8'h3C);
        alu_op = 4'h5; R = 8'h19; M = 8'h28; start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_busy1", {7'b0, busy}, 8'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {7'b0, busy}, 8'd0);
        chk("abort_vld", {7'b0, out_valid}, 8'd0);
        chk("abort_p", P, 8'h34);
        chk("abort_out", out, 8'h00);
        tick();
        chk("abort_vld2", {7'b0, out_valid}, 8'd0);

        // p_load wins over a simultaneous CLC.
        p_load = 1'b1; M = 8'hFF; flag_op = 3'd1;
        tick();
        p_load = 1'b0; flag_op = 3'd0;
        chk("pload_clc_p", P, 8'hFF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
